idex_pipe_reg: RTL and testbench
================================

# idex_pipe_reg

Parametrised ID/EX pipeline register for the five-stage MIPS datapath. It sits between the decode stage and the execute stage. On each clock it captures the decoded control bundle, the register operands, the sign-extended immediate and the register specifiers. It adds three things to a plain pass-through register:
- a stall (hold) control,
- a flush (bubble insert) control,
- a valid bit, plus saturating stall/bubble performance counters that the hazard unit and the test bench can read.

## Interface
Parameters:
- DATA_W, 32, width of operand and immediate fields
- REG_W, 5, width of register specifier fields
- CTRL_W, 8, width of packed control bundle (MemRead, MemWrite, MemtoReg, RegWrite, ALUSrc, ALUOp[1:0], RegDst)
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold all stage contents this cycle
- flush  in  1  load a bubble this cycle; has priority over stall
- cnt_clr  in  1  synchronous clear of both counters
- id_valid  in  1  decode stage holds a real instruction
- id_ctrl  in  CTRL_W  decoded control bundle
- id_rd1, id_rd2  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_W  register specifiers
- ex_valid  out  1  execute stage holds a real instruction
- ex_ctrl  out  CTRL_W  registered control bundle
- ex_rd1, ex_rd2, ex_imm  out  DATA_W  registered data
- ex_rs, ex_rt, ex_rd  out  REG_W  registered specifiers
- stall_cnt  out  CNT_W  count of held cycles
- bubble_cnt  out  CNT_W  count of bubbles entering EX

## Operation
- Reset (rst=1, asynchronous): every output, including both counters, goes to 0 immediately and stays 0 while rst is high.
- Each rising edge selects exactly one update mode, in priority order:
  1. **Flush** (flush=1, whatever stall is): ex_valid←0, ex_ctrl←0, all data and specifier fields←0.
  2. **Hold** (stall=1, flush=0): every stage output keeps its value.
  3. **Load** (stall=0, flush=0):
     - ex_valid←id_valid.
     - ex_ctrl←id_ctrl when id_valid=1, otherwise ex_ctrl←0.
     - Data and specifier fields←their id_* values unconditionally.
- Because the zero control bundle is the NOP encoding, a bubble never writes the register file or memory.
- stall_cnt: +1 on each edge in hold mode.
- bubble_cnt: +1 on each edge in flush mode, and on each load-mode edge with id_valid=0.
- Counter rules:
  - Both counters saturate at 2^CNT_W−1; they never wrap.
  - cnt_clr=1 sets both counters to 0 on that edge and overrides any increment.
  - cnt_clr does not affect the stage contents.
- All writes are nonblocking and all outputs come directly from registers; there is no combinational path from input to output.

## Timing
- Latency: 1 cycle. Values present on id_* at edge N appear on ex_* after edge N.
- stall and flush are sampled only at the rising edge. A level held for k cycles gives k hold cycles or k bubbles.
- Simultaneous stall and flush gives a bubble: the flush path is taken and stall_cnt does not increment.
- Counter updates and stage updates happen on the same edge. A counter value read in cycle N+1 reflects the mode taken at edge N.
- Reset during a stall or flush sequence clears everything at once. The first edge after rst falls behaves as a normal edge using the current stall/flush inputs.
- Saturation boundary: at stall_cnt=2^CNT_W−1, a further hold edge leaves it unchanged. The same applies to bubble_cnt.

## Test plan
- **Reset:** drive all id_* to nonzero values and assert rst mid-cycle. All outputs must read 0 before the next edge and stay 0 until one edge after rst is released.
- **Load:** id_valid=1, id_ctrl=8'hA5, id_rd1=32'h1234_5678, id_rs=5'd9, stall=flush=0. After one edge: ex_valid=1, ex_ctrl=8'hA5, ex_rd1=32'h1234_5678, ex_rs=9. Both counters stay 0.
- **Hold:** with the previous load in place, raise stall for 3 edges while changing all id_* inputs. The ex_* fields must stay unchanged and stall_cnt must read 3.
- **Flush over stall:** assert stall=1 and flush=1 together for one edge. Then ex_valid=0, ex_ctrl=0, ex_rd1=0, bubble_cnt increments by 1 and stall_cnt is unchanged.
- **Invalid load:** id_valid=0 with id_ctrl=8'hFF. Then ex_ctrl=0, ex_valid=0, and bubble_cnt increments by 1.
- **Saturation and clear** (CNT_W=4): hold for 20 edges and check stall_cnt=15. Pulse cnt_clr together with stall=1; after that edge stall_cnt=0, and it reads 1 after the next hold edge.

Source files
------------

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with hold, bubble insert, valid bit
// and saturating stall/bubble performance counters.
module idex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    M_LOAD  = 2'd0,
    M_HOLD  = 2'd1,
    M_FLUSH = 2'd2
  } mode_e;

  mode_e w_mode;
  logic  w_hold;
  logic  w_bubble;

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_rd;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  // Flush wins over stall; a load of an invalid slot is also a bubble.
  always_comb begin
    w_mode = M_LOAD;
    if (flush)
      w_mode = M_FLUSH;
    else if (stall)
      w_mode = M_HOLD;
  end

  assign w_hold   = (w_mode == M_HOLD);
  assign w_bubble = (w_mode == M_FLUSH) ||
                    ((w_mode == M_LOAD) && !id_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else if (w_mode == M_FLUSH) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else if (w_mode == M_LOAD) begin
      r_valid <= id_valid;
      r_ctrl  <= id_valid ? id_ctrl : '0;
      r_rd1   <= id_rd1;
      r_rd2   <= id_rd2;
      r_imm   <= id_imm;
      r_rs    <= id_rs;
      r_rt    <= id_rt;
      r_rd    <= id_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_hold && r_stall_cnt != CNT_MAX)
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_bubble && r_bubble_cnt != CNT_MAX)
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
    end
  end

  assign ex_valid   = r_valid;
  assign ex_ctrl    = r_ctrl;
  assign ex_rd1     = r_rd1;
  assign ex_rd2     = r_rd2;
  assign ex_imm     = r_imm;
  assign ex_rs      = r_rs;
  assign ex_rt      = r_rt;
  assign ex_rd      = r_rd;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Randomized bench for idex_pipe_reg against a behavioural model,
// plus directed reset/load/hold/flush/saturation sequences.
module tb_idex_pipe_reg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              cnt_clr = 1'b0;
  logic              id_valid = 1'b0;
  logic [CTRL_W-1:0] id_ctrl = '0;
  logic [DATA_W-1:0] id_rd1 = '0;
  logic [DATA_W-1:0] id_rd2 = '0;
  logic [DATA_W-1:0] id_imm = '0;
  logic [REG_W-1:0]  id_rs = '0;
  logic [REG_W-1:0]  id_rt = '0;
  logic [REG_W-1:0]  id_rd = '0;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_rd;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  idex_pipe_reg #(
    .DATA_W(DATA_W),
    .REG_W (REG_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .id_valid  (id_valid),
    .id_ctrl   (id_ctrl),
    .id_rd1    (id_rd1),
    .id_rd2    (id_rd2),
    .id_imm    (id_imm),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_rd     (id_rd),
    .ex_valid  (ex_valid),
    .ex_ctrl   (ex_ctrl),
    .ex_rd1    (ex_rd1),
    .ex_rd2    (ex_rd2),
    .ex_imm    (ex_imm),
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt),
    .ex_rd     (ex_rd),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int nchk = 0;

  // Reference state: what EX should hold, counters as plain integers.
  logic [31:0] m_valid, m_ctrl, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd;
  int m_scnt, m_bcnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_zero();
    m_valid = 0; m_ctrl = 0; m_rd1 = 0; m_rd2 = 0;
    m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0;
  endtask

  task automatic m_reset();
    m_zero();
    m_scnt = 0;
    m_bcnt = 0;
  endtask

  task automatic m_edge();
    bit is_hold, is_bub;
    is_hold = 0;
    is_bub  = 0;
    if (flush) begin
      m_zero();
      is_bub = 1;
    end else if (stall) begin
      is_hold = 1;
    end else begin
      m_valid = 32'(id_valid);
      m_ctrl  = id_valid ? 32'(id_ctrl) : 32'd0;
      m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
      m_rs = 32'(id_rs); m_rt = 32'(id_rt); m_rd = 32'(id_rd);
      is_bub = !id_valid;
    end
    if (cnt_clr) begin
      m_scnt = 0;
      m_bcnt = 0;
    end else begin
      if (is_hold) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
      if (is_bub)  m_bcnt = (m_bcnt < CMAX) ? m_bcnt + 1 : CMAX;
    end
  endtask

  task automatic chk_all(input string p);
    chk({p, ".valid"}, 32'(ex_valid), m_valid);
    chk({p, ".ctrl"},  32'(ex_ctrl),  m_ctrl);
    chk({p, ".rd1"},   ex_rd1,        m_rd1);
    chk({p, ".rd2"},   ex_rd2,        m_rd2);
    chk({p, ".imm"},   ex_imm,        m_imm);
    chk({p, ".rs"},    32'(ex_rs),    m_rs);
    chk({p, ".rt"},    32'(ex_rt),    m_rt);
    chk({p, ".rd"},    32'(ex_rd),    m_rd);
    chk({p, ".scnt"},  32'(stall_cnt),  32'(m_scnt));
    chk({p, ".bcnt"},  32'(bubble_cnt), 32'(m_bcnt));
  endtask

  // Called just after a falling edge; inputs already set.
  task automatic step(input string p);
    @(posedge clk);
    m_edge();
    @(negedge clk);
    chk_all(p);
  endtask

  task automatic rand_ids();
    id_valid = 1'b1;
    id_ctrl  = CTRL_W'($urandom);
    id_rd1   = $urandom;
    id_rd2   = $urandom;
    id_imm   = $urandom;
    id_rs    = REG_W'($urandom);
    id_rt    = REG_W'($urandom);
    id_rd    = REG_W'($urandom);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    chk_all("por");
    rst = 1'b0;
    rand_ids();
    step("pre1");
    step("pre2");

    // Async reset mid-cycle with nonzero inputs.
    #2 rst = 1'b1;
    m_reset();
    #1 chk_all("rst_async");
    @(negedge clk);
    chk_all("rst_hold");
    rst = 1'b0;
    #1 chk_all("rst_rel");

    // Load
    id_valid = 1'b1; id_ctrl = 8'hA5; id_rd1 = 32'h1234_5678;
    id_rs = 5'd9; stall = 1'b0; flush = 1'b0;
    step("load");
    chk("load.ctrlA5", 32'(ex_ctrl), 32'hA5);
    chk("load.rs9", 32'(ex_rs), 32'd9);

    // Hold for 3 edges while inputs change
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_ids();
      step("hold");
    end
    chk("hold.scnt3", 32'(stall_cnt), 32'd3);
    chk("hold.rd1", ex_rd1, 32'h1234_5678);

    // Flush over stall
    flush = 1'b1;
    step("fls");
    chk("fls.scnt3", 32'(stall_cnt), 32'd3);
    chk("fls.bcnt1", 32'(bubble_cnt), 32'd1);

    // Invalid load
    flush = 1'b0; stall = 1'b0;
    id_valid = 1'b0; id_ctrl = 8'hFF;
    step("inv");
    chk("inv.ctrl0", 32'(ex_ctrl), 32'd0);
    chk("inv.bcnt2", 32'(bubble_cnt), 32'd2);

    // Saturation
    stall = 1'b1;
    for (int i = 0; i < 20; i++) step("sat");
    chk("sat.scnt15", 32'(stall_cnt), 32'd15);

    cnt_clr = 1'b1;
    step("clr");
    chk("clr.scnt0", 32'(stall_cnt), 32'd0);
    cnt_clr = 1'b0;
    step("clr1");
    chk("clr1.scnt1", 32'(stall_cnt), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_ids();
      id_valid = ($urandom_range(3) != 0);
      stall    = ($urandom_range(9) < 4);
      flush    = ($urandom_range(9) < 2);
      cnt_clr  = ($urandom_range(29) == 0);
      if ($urandom_range(99) == 0) begin
        #2 rst = 1'b1;
        m_reset();
        #1 chk_all("rnd_rst");
        @(negedge clk);
        rst = 1'b0;
      end
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
